// File: rtl/lamp_pkg.sv
// Shared definitions for the multi-channel LED driver: mode encoding, ramp
// direction and elaboration-time helpers for the blink and breathe timers.
package lamp_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_DIM     = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Blink half-period in cycles, never below one.
  function automatic int unsigned blink_half(input int unsigned freq, input int unsigned hz);
    int unsigned h;
    h = freq / (2 * hz);
    return (h < 1) ? 1 : h;
  endfunction

  // Cycles per ramp step so that a full up+down sweep takes one breathe period.
  function automatic int unsigned breathe_step(input int unsigned freq, input int unsigned hz,
                                               input int unsigned bits);
    int unsigned s;
    s = freq / (hz * 2 * ((1 << bits) - 1));
    return (s < 1) ? 1 : s;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lamp_multi_if.sv
// Single-cycle configuration write port of the LED driver.
interface lamp_multi_if #(
  parameter int CW = 1,
  parameter int B  = 8
);
  logic          i_wr_en;
  logic [CW-1:0] i_wr_ch;
  logic [1:0]    i_wr_mode;
  logic [B-1:0]  i_wr_level;

  modport master (output i_wr_en, output i_wr_ch, output i_wr_mode, output i_wr_level);
  modport slave  (input  i_wr_en, input  i_wr_ch, input  i_wr_mode, input  i_wr_level);
endinterface

// File: rtl/lamp_channel.sv
// One LED channel: holds its mode/level, decodes writes addressed to it and
// registers its PWM/blink/breathe output from the shared timing signals.
module lamp_channel
  import lamp_pkg::*;
#(
  parameter int B   = 8,
  parameter int CW  = 1,
  parameter int IDX = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [CW-1:0] i_wr_ch,
  input  logic [1:0]    i_wr_mode,
  input  logic [B-1:0]  i_wr_level,
  input  logic [B-1:0]  i_cnt,
  input  logic          i_phase,
  input  logic [B-1:0]  i_ramp,
  output logic          o_led
);

  localparam logic [CW-1:0] MY_CH = CW'(IDX);

  mode_t        r_mode;
  logic [B-1:0] r_level;
  logic         r_led;
  logic         w_sel;
  logic         w_next;

  // Full scale is a solid 1; otherwise high while the counter is below x.
  function automatic logic pwm(input logic [B-1:0] x, input logic [B-1:0] c);
    return (x == {B{1'b1}}) || (c < x);
  endfunction

  // Out-of-range channel numbers match no instance and are dropped here.
  assign w_sel = i_wr_en && (i_wr_ch == MY_CH);

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = 1'b0;
    unique case (r_mode)
      MODE_OFF:     w_next = 1'b0;
      MODE_DIM:     w_next = pwm(r_level, i_cnt);
      MODE_BLINK:   w_next = i_phase && pwm(r_level, i_cnt);
      MODE_BREATHE: w_next = pwm(i_ramp, i_cnt);
      default:      w_next = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: configuration is a handful of flops, so it is reset along with the output.
      r_mode  <= MODE_OFF;
      r_level <= '0;
      r_led   <= 1'b0;
    end else begin
      if (w_sel) begin
        r_mode  <= mode_t'(i_wr_mode);
        r_level <= i_wr_level;
      end
      r_led <= w_next;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/lamp_multi.sv
// Multi-channel LED driver: shared PWM counter, blink phase and breathing ramp
// feeding one lamp_channel per output.
module lamp_multi
  import lamp_pkg::*;
#(
  parameter int unsigned c_freq       = 20000000,
  parameter int unsigned c_channels   = 2,
  parameter int unsigned c_pwm_bits   = 8,
  parameter int unsigned c_blink_hz   = 1,
  parameter int unsigned c_breathe_hz = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  lamp_multi_if.slave           wr_if,
  output logic [c_channels-1:0] o_led,
  output logic                  o_heartbeat
);

  localparam int unsigned B  = c_pwm_bits;
  localparam int unsigned CW = cnt_width(c_channels);
  localparam int unsigned H  = blink_half(c_freq, c_blink_hz);
  localparam int unsigned S  = breathe_step(c_freq, c_breathe_hz, c_pwm_bits);
  localparam int unsigned HW = cnt_width(H);
  localparam int unsigned SW = cnt_width(S);

  localparam logic [HW-1:0] H_LAST   = HW'(H - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(S - 1);
  localparam logic [B-1:0]  RAMP_TOP = {B{1'b1}};
  localparam logic [B-1:0]  RAMP_ONE = B'(1);

  logic [B-1:0]  r_cnt;
  logic [HW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [SW-1:0] r_step_cnt;
  logic [B-1:0]  r_ramp;
  dir_t          r_dir;
  logic          w_blink_tc;
  logic          w_step_tc;

  assign w_blink_tc = (r_blink_cnt == H_LAST);
  assign w_step_tc  = (r_step_cnt == S_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_step_cnt  <= '0;
      r_ramp      <= '0;
      r_dir       <= DIR_UP;
    end else begin
      // NOTE: non-blocking so every counter sees the pre-edge value of the others.
      r_cnt <= r_cnt + 1'b1;

      if (w_blink_tc) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      // Direction flips on the step that lands on an end, so the ramp never wraps.
      if (w_step_tc) begin
        r_step_cnt <= '0;
        if (r_dir == DIR_UP) begin
          r_ramp <= r_ramp + 1'b1;
          if (r_ramp == RAMP_TOP - 1'b1) r_dir <= DIR_DOWN;
        end else begin
          r_ramp <= r_ramp - 1'b1;
          if (r_ramp == RAMP_ONE) r_dir <= DIR_UP;
        end
      end else begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end
    end
  end

  assign o_heartbeat = r_phase;

  for (genvar i = 0; i < int'(c_channels); i++) begin : g_ch
    lamp_channel #(
      .B   (B),
      .CW  (CW),
      .IDX (i)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_en    (wr_if.i_wr_en),
      .i_wr_ch    (wr_if.i_wr_ch),
      .i_wr_mode  (wr_if.i_wr_mode),
      .i_wr_level (wr_if.i_wr_level),
      .i_cnt      (r_cnt),
      .i_phase    (r_phase),
      .i_ramp     (r_ramp),
      .o_led      (o_led[i])
    );
  end

endmodule

// File: tb/tb_lamp_multi.sv
// Self-checking bench for lamp_multi: directed checks of the PWM, blink and
// breathe behaviour plus randomized writes against a time-indexed reference model.
module tb_lamp_multi;
  import lamp_pkg::*;

  localparam int FREQ = 1000;
  localparam int NCH  = 3;
  localparam int B    = 4;
  localparam int H    = 50;
  localparam int S    = 33;
  localparam int FULL = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] led;
  logic           hb;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  lamp_multi_if #(.CW(2), .B(B)) wr_if ();

  lamp_multi #(
    .c_freq       (FREQ),
    .c_channels   (NCH),
    .c_pwm_bits   (B),
    .c_blink_hz   (10),
    .c_breathe_hz (1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .wr_if       (wr_if),
    .o_led       (led),
    .o_heartbeat (hb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every shared quantity is a closed-form function of the
  // number of clock edges t since reset release.
  int       t;
  int       cfg_mode  [NCH];
  int       cfg_level [NCH];
  logic [NCH-1:0] exp_led;

  function automatic logic pwm_ref(input int x, input int c);
    return (x == FULL) ? 1'b1 : (c < x);
  endfunction

  function automatic int ramp_ref(input int tt);
    int k;
    k = (tt / S) % (2 * FULL);
    return (k <= FULL) ? k : 2 * FULL - k;
  endfunction

  function automatic logic chan_ref(input int mode, input int level, input int tt);
    case (mode)
      1:       return pwm_ref(level, tt % 16);
      2:       return ((tt / H) % 2 == 1) && pwm_ref(level, tt % 16);
      3:       return pwm_ref(ramp_ref(tt), tt % 16);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t       <= 0;
      exp_led <= '0;
      for (int i = 0; i < NCH; i++) begin
        cfg_mode[i]  <= 0;
        cfg_level[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) exp_led[i] <= chan_ref(cfg_mode[i], cfg_level[i], t);
      if (wr_if.i_wr_en && int'(wr_if.i_wr_ch) < NCH) begin
        cfg_mode[wr_if.i_wr_ch]  <= int'(wr_if.i_wr_mode);
        cfg_level[wr_if.i_wr_ch] <= int'(wr_if.i_wr_level);
      end
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    check("led", 32'(led), 32'(exp_led));
    check("heartbeat", 32'(hb), 32'((t / H) % 2));
  end

  task automatic wr(input int ch, input int mode, input int level);
    wr_if.i_wr_en    = 1'b1;
    wr_if.i_wr_ch    = 2'(ch);
    wr_if.i_wr_mode  = 2'(mode);
    wr_if.i_wr_level = 4'(level);
    @(negedge clk);
    wr_if.i_wr_en = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      hits += int'(led[ch]);
    end
  endtask

  task automatic wait_until(input int target);
    int g = 0;
    while (t < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (t != target) check("wait_t", 32'(t), 32'(target));
  endtask

  task automatic wait_hb(input logic val);
    int g = 0;
    while (hb !== val && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (hb !== val) check("hb_timeout", 32'(hb), 32'(val));
  endtask

  task automatic wait_hb_rise();
    wait_hb(1'b0);
    wait_hb(1'b1);
  endtask

  int hits;
  int n;

  initial begin
    rst              = 1'b1;
    wr_if.i_wr_en    = 1'b0;
    wr_if.i_wr_ch    = '0;
    wr_if.i_wr_mode  = '0;
    wr_if.i_wr_level = '0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 0);
    check("reset_hb", 32'(hb), 0);
    rst = 1'b0;

    // First heartbeat rise H edges after release.
    n = 0;
    while (hb !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hb_first_rise", 32'(n), 32'(H));

    wr(2, MODE_BREATHE, 0);

    // DIM duty at low, full and zero level.
    wr(0, MODE_DIM, 4);
    @(negedge clk);
    count_high(0, 16, hits);
    check("dim4_duty", 32'(hits), 4);
    wr(0, MODE_DIM, 15);
    @(negedge clk);
    count_high(0, 16, hits);
    check("dim15_duty", 32'(hits), 16);
    wr(0, MODE_DIM, 0);
    @(negedge clk);
    count_high(0, 16, hits);
    check("dim0_duty", 32'(hits), 0);

    // Breathe rising: ramp 7 for t in [231,264).
    wait_until(240);
    count_high(2, 16, hits);
    check("breathe_r7", 32'(hits), 7);

    // BLINK at full level: lags heartbeat by the output register, 50 of 100 high.
    wr(1, MODE_BLINK, 15);
    wait_hb_rise();
    check("blink_lag", 32'(led[1]), 0);
    count_high(1, 100, hits);
    check("blink_duty", 32'(hits), 50);

    // Ramp at top is full scale, then descending, then back at 0 without wrapping.
    wait_until(500);
    count_high(2, 16, hits);
    check("breathe_r15", 32'(hits), 16);
    wait_until(800);
    count_high(2, 16, hits);
    check("breathe_r6_down", 32'(hits), 6);
    wait_until(995);
    count_high(2, 16, hits);
    check("breathe_r0", 32'(hits), 0);

    // Invalid channel writes do nothing; back-to-back writes both land.
    wr(3, MODE_DIM, 15);
    count_high(0, 16, hits);
    check("invalid_ch", 32'(hits), 0);
    wr(0, MODE_DIM, 15);
    wr(1, MODE_OFF, 0);
    check("b2b_ch0", 32'(led[0]), 1);
    @(negedge clk);
    check("b2b_ch1", 32'(led[1]), 0);
    check("b2b_ch0_hold", 32'(led[0]), 1);

    // BLINK -> OFF during the high phase.
    wr(0, MODE_BLINK, 15);
    wait_hb_rise();
    wr(0, MODE_OFF, 0);
    check("blink_pre_off", 32'(led[0]), 1);
    @(negedge clk);
    check("blink_to_off", 32'(led[0]), 0);

    // Write landing exactly on the falling blink toggle.
    wr(0, MODE_BLINK, 15);
    wait_hb_rise();
    repeat (H - 1) @(negedge clk);
    wr(0, MODE_DIM, 15);
    check("toggle_edge_hb", 32'(hb), 0);
    @(negedge clk);
    check("toggle_edge_wr", 32'(led[0]), 1);

    // Randomized writes, including the invalid channel, checked by the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr_if.i_wr_en    = 1'b1;
        wr_if.i_wr_ch    = 2'($urandom_range(0, 3));
        wr_if.i_wr_mode  = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       wr_if.i_wr_level = 4'd0;
          1:       wr_if.i_wr_level = 4'd15;
          default: wr_if.i_wr_level = 4'($urandom_range(0, 15));
        endcase
      end else begin
        wr_if.i_wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_if.i_wr_en = 1'b0;

    // Asynchronous reset mid-blink with ch0 lit.
    wr(0, MODE_BLINK, 15);
    wait_hb_rise();
    @(negedge clk);
    check("pre_reset_lit", 32'(led[0]), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 0);
    check("async_rst_hb", 32'(hb), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (120) begin
      @(negedge clk);
      hits += int'(|led);
    end
    check("post_reset_off", 32'(hits), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lamp_multi.md
# lamp_multi

Parametrised multi-channel LED driver that replaces the fixed two-LED `lamp` blinker. It drives `c_channels` LED outputs, each independently configured as OFF, DIM (static PWM), BLINK or BREATHE. All channels share a free-running PWM counter, a blink phase generator and a breathing ramp, all derived from `c_freq`. It sits between the board clock and the LED pins and is configured through a single-cycle write port.

## Interface
- `c_freq`, 20000000: input clock frequency in Hz.
- `c_channels`, 2: number of LED outputs, at least 1.
- `c_pwm_bits`, 8: PWM resolution B, at least 2.
- `c_blink_hz`, 1: blink frequency in Hz (one full on+off period).
- `c_breathe_hz`, 1: breathing frequency in Hz (one full up+down ramp).
- `i_clk`  in  1: system clock. One clock domain only.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_wr_en`  in  1: configuration write strobe, one cycle per write.
- `i_wr_ch`  in  CW = max(1, $clog2(c_channels)): target channel.
- `i_wr_mode`  in  2: 0 = OFF, 1 = DIM, 2 = BLINK, 3 = BREATHE.
- `i_wr_level`  in  B: brightness level.
- `o_led`  out  c_channels: LED drive, registered.
- `o_heartbeat`  out  1: shared blink phase, registered.

## Operation
- **PWM counter `cnt`** (B bits): increments every cycle and wraps from 2^B−1 to 0.
- **PWM function** `pwm(x)`:
  - x = 2^B−1 gives constant 1 (100% duty).
  - Otherwise it gives 1 when `cnt < x`, so x = 0 is always 0.
- **Blink generator:**
  - Half-period is H = c_freq / (2·c_blink_hz) cycles, integer floor, minimum 1.
  - A counter runs from 0 to H−1. On the terminal count it toggles `phase` and restarts at 0.
- **Breathe ramp** (B bits, with direction bit `dir`):
  - Step period is S = max(1, c_freq / (c_breathe_hz·2·(2^B−1))).
  - On each step terminal count, `ramp` moves by ±1.
  - When ramp reaches 2^B−1, `dir` goes down. When it reaches 0, `dir` goes up.
  - The ramp never overshoots or wraps.
- **Per-channel next output:**
  - OFF gives 0.
  - DIM gives pwm(level).
  - BLINK gives `phase` AND pwm(level).
  - BREATHE gives pwm(ramp); level is ignored.
- **Writes:**
  - When `i_wr_en` is high, the mode and level of channel `i_wr_ch` are loaded.
  - A write with `i_wr_ch` ≥ c_channels is ignored, with no side effects.
  - Writes never reset the shared counters. A channel switching to BLINK or BREATHE joins the current phase or ramp.
- `o_heartbeat` = `phase`.

## Timing
- **Reset (asynchronous):**
  - Clears `cnt`, the blink counter, `phase`, the step counter and `ramp` to 0, and sets `dir` to up.
  - All channels go to mode OFF, level 0.
  - `o_led` = 0 and `o_heartbeat` = 0 immediately on assertion, without waiting for a clock edge.
  - Reset asserted mid-operation aborts everything. The first edge after release runs from the reset state.
- **Output latency:** `o_led` at edge E+1 reflects `cnt`, `phase` and `ramp` as held after edge E. This is one register stage.
- **Write latency:** a write sampled at edge E updates the configuration at E. `o_led` shows the new mode from edge E+1.
- **PWM pattern:** DIM at level L (< 2^B−1) drives exactly L high cycles per 2^B-cycle window, contiguous.
- **Blink:** `o_heartbeat` toggles every H cycles. The first rise is H cycles after reset release.
- **Simultaneous terminal counts:** blink and step terminal counts falling on the same cycle are handled independently.
- **Throughput:** back-to-back writes (one per cycle) are all accepted.

## Structure
- **Package `lamp_pkg`:**
  - Mode encoding constants: `MODE_OFF`, `MODE_DIM`, `MODE_BLINK`, `MODE_BREATHE`.
  - Helper functions computing H and S from the parameters.
- **Sub-module `lamp_channel`, instantiated per channel:**
  - Contains the mode/level registers, the write decode compare, and the output mux and register.
  - Its inputs are the shared `cnt`, `phase` and `ramp`.
- **Top level** holds the shared counters, the blink generator, the ramp, and the generate loop.

## Test plan
Bench parameters: c_freq = 1000, B = 4, c_blink_hz = 10 (so H = 50), c_breathe_hz = 1 (so S = 33), c_channels = 3.
1. **Reset:** assert `i_rst` mid-blink with `o_led[0]` = 1. Required: `o_led` = 0 and `o_heartbeat` = 0 before the next edge, and all channels read OFF after release.
2. **DIM level 4 on ch0:** required exactly 4 high cycles per 16-cycle window. Level 15 must give constant 1, and level 0 constant 0.
3. **BLINK level 15 on ch1:** required 50 cycles high and 50 cycles low, aligned with `o_heartbeat` toggling every 50 cycles.
4. **BREATHE on ch2:** required `ramp` = 15 after 15·33 cycles and back to 0 after 30·33 cycles. Per-window duty must equal the ramp value, with no wrap.
5. **Write to ch3 (invalid) with mode DIM:** required no change on any `o_led` bit. Back-to-back writes to ch0 then ch1 must both take effect, each with one-cycle output latency.
6. **Simultaneous events:** a write on the cycle of a blink toggle must be applied. Switching ch0 from BLINK to OFF during the high phase must give 0 from the next edge.
